// File: rtl/pipe_seq.sv
// Purpose: power sequencer; PDM mic clock warm-up, then stage enables ramp up and ramp down in reverse order.
// Latency: all outputs are registered; mic rises on the edge that samples en_i, stage i at +WARMUP+i*GAP, ready at +WARMUP+N*GAP.
// Backpressure: none; en_i is level-sensitive, and a re-request during ramp-down waits until OFF is reached.
module pipe_seq #(
  parameter int NUM_STAGES    = 4,
  parameter int WARMUP_CYCLES = 10,
  parameter int STAGE_GAP     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  output logic                  mic_clk_en_o,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  // Shared counter covers both the warm-up window and the inter-stage gap.
  localparam int CNT_MAX = (WARMUP_CYCLES > STAGE_GAP) ? WARMUP_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(NUM_STAGES);
  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_WARMUP    = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_ON        = 3'd3,
    S_RAMP_DOWN = 3'd4
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;      // number of stage bits currently set
  logic                    r_mic;
  logic [NUM_STAGES-1:0]   r_stage;
  logic                    r_ready;
  logic                    r_busy;

  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic                    w_mic_nxt;
  logic [NUM_STAGES-1:0]   w_stage_nxt;
  logic                    w_ready_nxt;
  logic                    w_busy_nxt;

  // Stage enables are kept as a thermometer code: growing shifts a 1 in at
  // bit 0, shrinking drops the highest set bit, so upstream-before-downstream
  // ordering holds by construction.
  logic [NUM_STAGES-1:0]   w_stage_grow;
  logic [NUM_STAGES-1:0]   w_stage_shrink;
  assign w_stage_grow   = (r_stage << 1) | NUM_STAGES'(1);
  assign w_stage_shrink = r_stage >> 1;

  // State, counters and registered outputs; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_mic   <= 1'b0;
      r_stage <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_mic   <= w_mic_nxt;
      r_stage <= w_stage_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state and next-output decode; every path starts from "hold".
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_mic_nxt   = r_mic;
    w_stage_nxt = r_stage;
    w_ready_nxt = r_ready;

    case (r_state)
      S_OFF: begin
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_mic_nxt   = 1'b0;
        w_stage_nxt = '0;
        w_ready_nxt = 1'b0;
        if (en_i) begin
          w_state_nxt = S_WARMUP;
          w_mic_nxt   = 1'b1;
        end
      end

      S_WARMUP: begin
        w_mic_nxt   = 1'b1;
        w_stage_nxt = '0;
        w_ready_nxt = 1'b0;
        if (!en_i) begin
          // Nothing downstream is on yet, so drop straight back to OFF.
          w_state_nxt = S_OFF;
          w_mic_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == WARM_LAST) begin
          w_state_nxt = S_RAMP_UP;
          w_stage_nxt = NUM_STAGES'(1);
          w_idx_nxt   = IDX_W'(1);
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_RAMP_UP: begin
        if (!en_i) begin
          // Abort: unwind from the highest stage already enabled.
          w_state_nxt = S_RAMP_DOWN;
          w_stage_nxt = w_stage_shrink;
          w_idx_nxt   = r_idx - IDX_W'(1);
          w_cnt_nxt   = '0;
        end else if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_FULL) begin
            // Last stage has had a full gap to settle.
            w_state_nxt = S_ON;
            w_ready_nxt = 1'b1;
          end else begin
            w_stage_nxt = w_stage_grow;
            w_idx_nxt   = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_ON: begin
        if (!en_i) begin
          w_state_nxt = S_RAMP_DOWN;
          w_ready_nxt = 1'b0;
          w_stage_nxt = w_stage_shrink;
          w_idx_nxt   = r_idx - IDX_W'(1);
          w_cnt_nxt   = '0;
        end
      end

      S_RAMP_DOWN: begin
        // en_i is deliberately ignored here: the ramp-down always completes.
        w_ready_nxt = 1'b0;
        if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == IDX_ZERO) begin
            w_state_nxt = S_OFF;
            w_mic_nxt   = 1'b0;
          end else begin
            w_stage_nxt = w_stage_shrink;
            w_idx_nxt   = r_idx - IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_OFF;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_mic_nxt   = 1'b0;
        w_stage_nxt = '0;
        w_ready_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_OFF);
  end

  assign mic_clk_en_o = r_mic;
  assign stage_en_o   = r_stage;
  assign ready_o      = r_ready;
  assign busy_o       = r_busy;

endmodule
